tetris_input_arbiter: RTL and testbench

Front-end command source for the tetris game core. It turns debounced button levels, a gravity timer and a queue of incoming garbage rows into a stream of single-cycle `state_type` commands on the core's `ctrl` input, plus `bar_mask` for BAR commands. It issues a command only when the core reports WAIT, so no request is lost while the core is busy in a multi-cycle check or clear sequence.

---
 rtl/tetris_input_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tetris_input_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_input_arbiter.sv
// rtl/tetris_input_arbiter.sv - turns buttons, gravity and garbage rows into one-cycle core commands
// Commands are launched only while the core idles in WAIT; everything else is latched as pending.
package enum_type;
  typedef enum logic [3:0] {
    NONE, INIT, GEN, WAIT, PCHECK, CLEAR, END,
    DOWN, LEFT, RIGHT, ROTATE, ROTATE_REV, DROP, HOLD, BAR
  } state_type;
endpackage

module tetris_input_arbiter
  import enum_type::*;
#(
  parameter int GRAVITY_CYCLES = 50_000_000,
  parameter int DAS_CYCLES     = 17_000_000,
  parameter int ARR_CYCLES     = 5_000_000,
  parameter int BAR_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  state_type   state,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_rotate_rev,
  input  logic        btn_down,
  input  logic        btn_drop,
  input  logic        btn_hold,
  input  logic [3:0]  speed,
  input  logic        bar_valid,
  output logic        bar_ready,
  input  logic [9:0]  bar_data,
  output state_type   ctrl,
  output logic [9:0]  bar_mask,
  output logic [2:0]  bar_count
);

  localparam int MAXP = (GRAVITY_CYCLES > DAS_CYCLES)
                      ? ((GRAVITY_CYCLES > ARR_CYCLES) ? GRAVITY_CYCLES : ARR_CYCLES)
                      : ((DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES);
  localparam int CW = $clog2(MAXP + 1);
  localparam int AW = $clog2(BAR_DEPTH);
  localparam logic [CW-1:0] DAS_LIM = CW'(DAS_CYCLES);
  localparam logic [CW-1:0] ARR_LIM = CW'(ARR_CYCLES);

  // Bit order is the issue priority: hold, rotate, rotate_rev, left, right, drop, down.
  logic [6:0]    btn, btn_q, rise, set_v, pend, clr;
  logic          run, grav_pend, grav_fire, clr_grav, pop, store;
  logic [CW-1:0] grav_cnt, grav_period;
  logic [CW-1:0] rep_cnt [3];
  logic [2:0]    rep_das, rep_btn, rep_fire;
  logic [9:0]    mem [BAR_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_type     cmd;

  assign btn   = {btn_down, btn_drop, btn_right, btn_left, btn_rotate_rev, btn_rotate, btn_hold};
  assign rise  = btn & ~btn_q;
  assign run   = (state != INIT) && (state != END);
  assign set_v = rise | {rep_fire[2], 1'b0, rep_fire[1], rep_fire[0], 3'b000};

  assign grav_period = CW'(GRAVITY_CYCLES) >> speed;
  assign grav_fire   = run && (state != GEN) && (grav_cnt == grav_period - CW'(1));

  assign bar_ready = bar_count < 3'(BAR_DEPTH);
  assign store     = bar_valid && bar_ready && (state != INIT) && (bar_data != 10'h3FF);

  // Repeat channels: 0 = left, 1 = right, 2 = down (down skips the DAS phase).
  assign rep_btn = {btn[6], btn[4], btn[3]};
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 3; i++) begin
      rep_fire[i] = run && rep_btn[i] &&
                    (rep_cnt[i] == ((rep_das[i] || (i == 2)) ? ARR_LIM : DAS_LIM));
    end
  end

  always_comb begin
    cmd      = NONE;
    clr      = '0;
    clr_grav = 1'b0;
    pop      = 1'b0;
    if (!run) begin
      if ((|rise) && (ctrl == NONE)) cmd = DOWN;
    end else if ((state == WAIT) && (ctrl == NONE)) begin
      if (pend[0]) begin
        cmd = HOLD; clr[0] = 1'b1;
      end else if (pend[1]) begin
        cmd = ROTATE; clr[1] = 1'b1;
      end else if (pend[2]) begin
        cmd = ROTATE_REV; clr[2] = 1'b1;
      end else if (pend[3]) begin
        cmd = LEFT; clr[3] = 1'b1;
      end else if (pend[4]) begin
        cmd = RIGHT; clr[4] = 1'b1;
      end else if (pend[5]) begin
        cmd = DROP; clr[5] = 1'b1; clr_grav = 1'b1;
      end else if (pend[6] || grav_pend) begin
        cmd = DOWN; clr[6] = 1'b1; clr_grav = 1'b1;
      end else if (bar_count != 3'd0) begin
        cmd = BAR; pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q     <= '0;
      pend      <= '0;
      grav_pend <= 1'b0;
      grav_cnt  <= '0;
    end else begin
      btn_q <= btn;
      if (!run) begin
        pend      <= '0;
        grav_pend <= 1'b0;
      end else begin
        pend      <= (pend & ~clr) | set_v;
        grav_pend <= (grav_pend & ~clr_grav) | grav_fire;
      end
      if (state == GEN) grav_cnt <= '0;
      else if (run)     grav_cnt <= grav_fire ? '0 : grav_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_das <= '0;
      for (int i = 0; i < 3; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!run || !rep_btn[i]) begin
          rep_cnt[i] <= '0;
          rep_das[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i] <= CW'(1);
          rep_das[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rows without a hole are dropped at the door; INIT flushes the queue.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= bar_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bar_count <= '0;
    end else if (state == INIT) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bar_count <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      bar_count <= bar_count + 3'(store) - 3'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= NONE;
      bar_mask <= '0;
    end else begin
      ctrl     <= cmd;
      bar_mask <= pop ? mem[rd_ptr] : 10'd0;
    end
  end

endmodule

// File: tb/tb_tetris_input_arbiter.sv
// tb/tb_tetris_input_arbiter.sv - self-checking bench for tetris_input_arbiter
module tb_tetris_input_arbiter;
  import enum_type::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 0, btn_right = 0, btn_rotate = 0, btn_rotate_rev = 0;
  logic       btn_down = 0, btn_drop = 0, btn_hold = 0;
  logic [3:0] speed = 4'd15;
  logic       bar_valid = 0;
  logic       bar_ready;
  logic [9:0] bar_data = '0;
  state_type  ctrl;
  logic [9:0] bar_mask;
  logic [2:0] bar_count;
  state_type  state, forced_state = PCHECK, model_state = WAIT;
  logic       core_auto = 1'b0;
  int         busy = 0;

  always #5 clk = ~clk;

  tetris_input_arbiter #(
    .GRAVITY_CYCLES(100), .DAS_CYCLES(20), .ARR_CYCLES(5), .BAR_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .state(state),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .btn_rotate_rev(btn_rotate_rev), .btn_down(btn_down), .btn_drop(btn_drop),
    .btn_hold(btn_hold), .speed(speed), .bar_valid(bar_valid), .bar_ready(bar_ready),
    .bar_data(bar_data), .ctrl(ctrl), .bar_mask(bar_mask), .bar_count(bar_count)
  );

  assign state = core_auto ? model_state : forced_state;

  // Core model: leaves WAIT after accepting a command, back in WAIT three cycles later.
  always @(negedge clk) begin
    if (reset || !core_auto) begin
      model_state = WAIT;
      busy = 0;
    end else if (busy > 0) begin
      busy = busy - 1;
      if (busy == 0) model_state = WAIT;
    end else if (model_state == WAIT && ctrl != NONE) begin
      model_state = PCHECK;
      busy = 2;
    end
  end

  int n_tests = 0, n_fail = 0;
  state_type cmd_q[$];
  logic [9:0] mask_q[$];
  int mask_bad;
  state_type prio [7] = '{HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DROP, DOWN};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [6:0] m);
    btn_hold = m[0]; btn_rotate = m[1]; btn_rotate_rev = m[2]; btn_left = m[3];
    btn_right = m[4]; btn_drop = m[5]; btn_down = m[6];
  endtask

  task automatic do_reset();
    core_auto = 0; forced_state = PCHECK; set_btns(7'd0);
    bar_valid = 0; bar_data = '0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic push_row(input logic [9:0] d);
    bar_valid = 1; bar_data = d;
    @(negedge clk);
    bar_valid = 0;
  endtask

  task automatic collect(input int n);
    cmd_q.delete(); mask_q.delete(); mask_bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (ctrl != NONE) begin
        cmd_q.push_back(ctrl);
        mask_q.push_back(bar_mask);
      end
      if (ctrl != BAR && bar_mask != 10'd0) mask_bad++;
    end
  endtask

  typedef struct {
    logic [6:0] btns;
    state_type  exp;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int first_left, second_left, last_left, n_left, n_down, found;
    logic [9:0] rows [5];
    logic [9:0] fq[$];
    logic [9:0] d;
    logic [6:0] m;
    int with_bar, n;
    state_type exp_q[$];

    vecs[0]  = '{7'b0000001, HOLD};
    vecs[1]  = '{7'b0000010, ROTATE};
    vecs[2]  = '{7'b0000100, ROTATE_REV};
    vecs[3]  = '{7'b0001000, LEFT};
    vecs[4]  = '{7'b0010000, RIGHT};
    vecs[5]  = '{7'b0100000, DROP};
    vecs[6]  = '{7'b1000000, DOWN};
    vecs[7]  = '{7'b0010100, ROTATE_REV};
    vecs[8]  = '{7'b1100000, DROP};
    vecs[9]  = '{7'b0110000, RIGHT};
    vecs[10] = '{7'b0011000, LEFT};

    // Reset values
    reset = 1;
    @(negedge clk);
    check("reset_ctrl", int'(ctrl), int'(NONE));
    check("reset_mask", int'(bar_mask), 0);
    check("reset_count", int'(bar_count), 0);
    check("reset_ready", int'(bar_ready), 1);

    // Table: one-cycle press in WAIT, command two cycles later, highest priority first
    foreach (vecs[v]) begin
      do_reset(); speed = 15; core_auto = 1;
      @(negedge clk);
      set_btns(vecs[v].btns);
      @(negedge clk);
      set_btns(7'd0);
      check($sformatf("vec%0d_t1_idle", v), int'(ctrl), int'(NONE));
      @(negedge clk);
      check($sformatf("vec%0d_t2_cmd", v), int'(ctrl), int'(vecs[v].exp));
      collect(22);
      check($sformatf("vec%0d_rest", v), cmd_q.size(), $countones(vecs[v].btns) - 1);
    end

    // Auto-repeat: hold left cycles 0..59
    do_reset(); speed = 15; core_auto = 1;
    @(negedge clk);
    btn_left = 1;
    first_left = -1; second_left = -1; last_left = -1; n_left = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (ctrl == LEFT) begin
        n_left++;
        if (first_left < 0) first_left = c;
        else if (second_left < 0) second_left = c;
        last_left = c;
      end
      if (c == 60) btn_left = 0;
    end
    check("rep_first", first_left, 2);
    check("rep_second", second_left, 22);
    check("rep_total", n_left, 9);
    check("rep_stops", int'(last_left <= 61), 1);

    // Gravity at speed 0 and 1
    for (int s = 0; s < 2; s++) begin
      do_reset(); speed = 4'(s); core_auto = 1;
      n_down = 0;
      for (int c = 0; c < 360; c++) begin
        @(negedge clk);
        if (ctrl == DOWN) n_down++;
      end
      check($sformatf("grav_speed%0d", s), n_down, (s == 0) ? 3 : 7);
    end

    // Garbage FIFO fill and drain
    do_reset(); speed = 15;
    @(negedge clk);
    push_row(10'h3FF);
    check("fifo_noHole_discard", int'(bar_count), 0);
    rows = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fifo_ready%0d", i), int'(bar_ready), (i < 4) ? 1 : 0);
      push_row(rows[i]);
    end
    check("fifo_full_ready", int'(bar_ready), 0);
    check("fifo_full_count", int'(bar_count), 4);
    core_auto = 1;
    collect(30);
    check("fifo_nbar", cmd_q.size(), 4);
    for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
      check($sformatf("fifo_cmd%0d", i), int'(cmd_q[i]), int'(BAR));
      check($sformatf("fifo_mask%0d", i), int'(mask_q[i]), int'(rows[i]));
    end
    check("fifo_mask_idle", mask_bad, 0);
    check("fifo_empty_count", int'(bar_count), 0);

    // Priority: same-cycle hold+rotate+left plus a queued bar
    do_reset(); speed = 15;
    @(negedge clk);
    push_row(10'h020);
    set_btns(7'b0001011);
    @(negedge clk);
    set_btns(7'd0);
    @(negedge clk);
    core_auto = 1;
    collect(30);
    exp_q = '{HOLD, ROTATE, LEFT, BAR};
    check("prio_n", cmd_q.size(), 4);
    for (int i = 0; i < 4 && i < cmd_q.size(); i++)
      check($sformatf("prio_%0d", i), int'(cmd_q[i]), int'(exp_q[i]));

    // INIT: drop press gives one DOWN token, FIFO flushed, nothing retained
    do_reset(); speed = 15;
    @(negedge clk);
    push_row(10'h011);
    push_row(10'h022);
    check("init_pre_count", int'(bar_count), 2);
    forced_state = INIT;
    @(negedge clk);
    btn_drop = 1;
    collect(3);
    btn_drop = 0;
    begin
      state_type q1[$];
      q1 = cmd_q;
      collect(7);
      check("init_ncmd", q1.size() + cmd_q.size(), 1);
      if (q1.size() > 0) check("init_cmd", int'(q1[0]), int'(DOWN));
      else check("init_cmd", int'(NONE), int'(DOWN));
    end
    check("init_flush", int'(bar_count), 0);
    core_auto = 1;
    collect(10);
    check("init_no_residue", cmd_q.size(), 0);

    // Reset while ctrl = LEFT
    do_reset(); speed = 15;
    @(negedge clk);
    push_row(10'h0F0);
    set_btns(7'b0001000);
    @(negedge clk);
    set_btns(7'd0);
    core_auto = 1;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (ctrl == LEFT) found = 1;
    end
    check("rst_saw_left", found, 1);
    reset = 1;
    #1;
    check("rst_ctrl_async", int'(ctrl), int'(NONE));
    check("rst_count_async", int'(bar_count), 0);
    check("rst_ready_async", int'(bar_ready), 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_first_cycle", int'(ctrl), int'(NONE));
    collect(10);
    check("rst_no_residue", cmd_q.size(), 0);

    // Random button sets against the priority model
    for (int r = 0; r < 12; r++) begin
      m = 7'($urandom_range(1, 127));
      with_bar = $urandom_range(0, 1);
      do_reset(); speed = 15;
      @(negedge clk);
      if (with_bar != 0) push_row(10'($urandom_range(0, 1022)));
      set_btns(m);
      @(negedge clk);
      set_btns(7'd0);
      @(negedge clk);
      core_auto = 1;
      collect(45);
      exp_q.delete();
      for (int i = 0; i < 7; i++) if (m[i]) exp_q.push_back(prio[i]);
      if (with_bar != 0) exp_q.push_back(BAR);
      check($sformatf("rbtn%0d_n", r), cmd_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++)
        check($sformatf("rbtn%0d_c%0d", r, i), int'(cmd_q[i]), int'(exp_q[i]));
    end

    // Random FIFO traffic against a queue model
    do_reset(); speed = 15;
    fq.delete();
    for (int r = 0; r < 20; r++) begin
      core_auto = 0; forced_state = PCHECK;
      @(negedge clk);
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        check("rfifo_ready", int'(bar_ready), int'(fq.size() < 4));
        check("rfifo_count", int'(bar_count), fq.size());
        if ($urandom_range(0, 3) == 0) begin
          bar_valid = 0;
        end else begin
          d = ($urandom_range(0, 4) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022));
          bar_valid = 1; bar_data = d;
          if (fq.size() < 4 && d != 10'h3FF) fq.push_back(d);
        end
        @(negedge clk);
      end
      bar_valid = 0;
      core_auto = 1;
      collect(30);
      foreach (cmd_q[i]) begin
        if (cmd_q[i] == BAR) begin
          if (fq.size() > 0) check($sformatf("rfifo%0d_mask", r), int'(mask_q[i]), int'(fq.pop_front()));
          else check($sformatf("rfifo%0d_extra_bar", r), int'(mask_q[i]), -1);
        end
      end
      check($sformatf("rfifo%0d_drained", r), fq.size(), 0);
      check($sformatf("rfifo%0d_count0", r), int'(bar_count), 0);
      fq.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
